// File: rtl/sha_stream_core.sv
// sha_stream_core: streaming SHA-0/SHA-1 engine that absorbs one 64-byte block at a time.
// Optional midstate resume (caller IV + already-hashed prefix length) under `SHA_MIDSTATE_EN.
module sha_stream_core #(
   parameter int unsigned LEN_W    = 32,
   parameter int unsigned IN_BYTES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [LEN_W-1:0]      msg_len,
   input  logic                  mode_sha1,
   output logic                  busy,
   input  logic                  in_valid,
   input  logic [8*IN_BYTES-1:0] in_data,
   output logic                  in_ready,
`ifdef SHA_MIDSTATE_EN
   input  logic                  iv_load,
   input  logic [159:0]          iv,
   input  logic [63:0]           prefix_len,
`endif
   output logic [159:0]          digest,
   output logic                  digest_valid
);

   localparam int unsigned CNT_W = 7;

   typedef enum logic [2:0] {IDLE, ABSORB, ROUNDS, ACCUM, PAD, DONE} state_t;

   state_t             state, state_n;
   logic [31:0]        h [5];
   logic [31:0]        h_n [5];
   logic [31:0]        w [16];
   logic [31:0]        w_n [16];
   logic [31:0]        a, b, c, d, e, a_n, b_n, c_n, d_n, e_n;
   logic [CNT_W-1:0]   rnd, rnd_n, blk, blk_n;
   logic [LEN_W-1:0]   len_q, len_n, cons, cons_n;
   logic               mode_q, mode_n, pad80, pad80_n, ztail, ztail_n, padded, padded_n;
   logic               busy_n, in_ready_n, dv_n;
   logic [159:0]       digest_n;
   logic [63:0]        bitlen;
   logic [LEN_W-1:0]   rem;
   logic [2:0]         nb;
   logic [CNT_W-1:0]   off;
   logic [3:0]         ridx;
   logic [31:0]        wt, f, kc, tmp;
   logic [7:0]         pbyte;
   logic               zt;

`ifdef SHA_MIDSTATE_EN
   logic [63:0]        pre_q, pre_n;
   assign bitlen = (pre_q + 64'(len_q)) << 3;
`else
   assign bitlen = 64'(len_q) << 3;
`endif

   // State and datapath registers; reset aborts any message in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         for (int i = 0; i < 5; i++) h[i] <= '0;
         for (int i = 0; i < 16; i++) w[i] <= '0;
         a <= '0; b <= '0; c <= '0; d <= '0; e <= '0;
         rnd          <= '0;
         blk          <= '0;
         len_q        <= '0;
         cons         <= '0;
         mode_q       <= 1'b0;
         pad80        <= 1'b0;
         ztail        <= 1'b0;
         padded       <= 1'b0;
         busy         <= 1'b0;
         in_ready     <= 1'b0;
         digest       <= '0;
         digest_valid <= 1'b0;
`ifdef SHA_MIDSTATE_EN
         pre_q        <= '0;
`endif
      end else begin
         state        <= state_n;
         h            <= h_n;
         w            <= w_n;
         a <= a_n; b <= b_n; c <= c_n; d <= d_n; e <= e_n;
         rnd          <= rnd_n;
         blk          <= blk_n;
         len_q        <= len_n;
         cons         <= cons_n;
         mode_q       <= mode_n;
         pad80        <= pad80_n;
         ztail        <= ztail_n;
         padded       <= padded_n;
         busy         <= busy_n;
         in_ready     <= in_ready_n;
         digest       <= digest_n;
         digest_valid <= dv_n;
`ifdef SHA_MIDSTATE_EN
         pre_q        <= pre_n;
`endif
      end
   end

   // Next-state, block assembly, compression round and padding control.
   always_comb begin
      state_n  = state;
      h_n      = h;
      w_n      = w;
      a_n = a; b_n = b; c_n = c; d_n = d; e_n = e;
      rnd_n    = rnd;
      blk_n    = blk;
      len_n    = len_q;
      cons_n   = cons;
      mode_n   = mode_q;
      pad80_n  = pad80;
      ztail_n  = ztail;
      padded_n = padded;
      busy_n   = busy;
      digest_n = digest;
      dv_n     = 1'b0;
      rem      = '0;
      nb       = '0;
      off      = '0;
      ridx     = rnd[3:0];
      wt       = '0;
      f        = '0;
      kc       = '0;
      tmp      = '0;
      pbyte    = '0;
      zt       = ztail;
`ifdef SHA_MIDSTATE_EN
      pre_n    = pre_q;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               len_n    = msg_len;
               mode_n   = mode_sha1;
               h_n[0]   = 32'h67452301;
               h_n[1]   = 32'hEFCDAB89;
               h_n[2]   = 32'h98BADCFE;
               h_n[3]   = 32'h10325476;
               h_n[4]   = 32'hC3D2E1F0;
`ifdef SHA_MIDSTATE_EN
               if (iv_load) begin
                  h_n[0] = iv[159:128];
                  h_n[1] = iv[127:96];
                  h_n[2] = iv[95:64];
                  h_n[3] = iv[63:32];
                  h_n[4] = iv[31:0];
               end
               pre_n    = prefix_len;
`endif
               cons_n   = '0;
               blk_n    = '0;
               pad80_n  = 1'b0;
               ztail_n  = 1'b0;
               padded_n = 1'b0;
               busy_n   = 1'b1;
               state_n  = (msg_len == '0) ? PAD : ABSORB;
            end
         end
         ABSORB: begin
            if (in_valid && in_ready) begin
               rem = len_q - cons;
               nb  = (rem < LEN_W'(IN_BYTES)) ? 3'(rem) : 3'(IN_BYTES);
               for (int k = 0; k < IN_BYTES; k++) begin
                  if (3'(k) < nb) begin
                     off = blk + CNT_W'(k);
                     w_n[off[5:2]][{~off[1:0], 3'b000} +: 8] = in_data[8*(IN_BYTES-k)-1 -: 8];
                  end
               end
               cons_n = cons + LEN_W'(nb);
               blk_n  = blk + CNT_W'(nb);
               if (blk_n == CNT_W'(64)) begin
                  state_n = ROUNDS;
                  blk_n   = '0;
                  rnd_n   = '0;
                  a_n = h[0]; b_n = h[1]; c_n = h[2]; d_n = h[3]; e_n = h[4];
               end else if (cons_n == len_q) begin
                  state_n = PAD;
               end
            end
         end
         ROUNDS: begin
            if (rnd < CNT_W'(16)) begin
               wt = w[ridx];
            end else begin
               wt = w[4'(ridx + 4'd13)] ^ w[4'(ridx + 4'd8)] ^ w[4'(ridx + 4'd2)] ^ w[ridx];
               if (mode_q) wt = {wt[30:0], wt[31]};
               w_n[ridx] = wt;
            end
            if (rnd < CNT_W'(20)) begin
               f  = (b & c) | (~b & d);
               kc = 32'h5A827999;
            end else if (rnd < CNT_W'(40)) begin
               f  = b ^ c ^ d;
               kc = 32'h6ED9EBA1;
            end else if (rnd < CNT_W'(60)) begin
               f  = (b & c) | (b & d) | (c & d);
               kc = 32'h8F1BBCDC;
            end else begin
               f  = b ^ c ^ d;
               kc = 32'hCA62C1D6;
            end
            tmp = {a[26:0], a[31:27]} + f + e + kc + wt;
            a_n = tmp;
            b_n = a;
            c_n = {b[1:0], b[31:2]};
            d_n = c;
            e_n = d;
            rnd_n = rnd + CNT_W'(1);
            if (rnd == CNT_W'(79)) state_n = ACCUM;
         end
         ACCUM: begin
            h_n[0] = h[0] + a;
            h_n[1] = h[1] + b;
            h_n[2] = h[2] + c;
            h_n[3] = h[3] + d;
            h_n[4] = h[4] + e;
            if (cons != len_q)  state_n = ABSORB;
            else if (!padded)   state_n = PAD;
            else                state_n = DONE;
         end
         PAD: begin
            // 0x80 landing in bytes 56..63 forces this block's tail to zero and a second pad block
            if (!pad80) begin
               pbyte   = 8'h80;
               pad80_n = 1'b1;
               if (blk >= CNT_W'(56)) zt = 1'b1;
            end else if (blk >= CNT_W'(56) && !ztail) begin
               pbyte = bitlen[{~blk[2:0], 3'b000} +: 8];
            end
            w_n[blk[5:2]][{~blk[1:0], 3'b000} +: 8] = pbyte;
            ztail_n = zt;
            if (blk == CNT_W'(63)) begin
               padded_n = !zt;
               ztail_n  = 1'b0;
               state_n  = ROUNDS;
               blk_n    = '0;
               rnd_n    = '0;
               a_n = h[0]; b_n = h[1]; c_n = h[2]; d_n = h[3]; e_n = h[4];
            end else begin
               blk_n = blk + CNT_W'(1);
            end
         end
         DONE: begin
            digest_n = {h[0], h[1], h[2], h[3], h[4]};
            dv_n     = 1'b1;
            busy_n   = 1'b0;
            state_n  = IDLE;
         end
         default: state_n = IDLE;
      endcase
      in_ready_n = (state_n == ABSORB);
   end

endmodule

// File: tb/tb_sha_stream_core.sv
// tb_sha_stream_core: directed known-answer tests on a byte-wide and a 4-byte-wide core.
module tb_sha_stream_core;

   localparam logic [159:0] SHA1_ABC   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
   localparam logic [159:0] SHA0_ABC   = 160'h0164b8a9_14cd2a5e_74c4f7ff_082c4d97_f1edf880;
   localparam logic [159:0] SHA1_EMPTY = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
   localparam logic [159:0] SHA1_56B   = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

   logic         clk, rst;
   logic         s1_start, s1_mode, s1_valid;
   logic [31:0]  s1_len;
   logic [7:0]   s1_data;
   logic         d1_busy, d1_ready, d1_dv;
   logic [159:0] d1_digest;
   logic         s4_start, s4_mode, s4_valid;
   logic [31:0]  s4_len;
   logic [31:0]  s4_data;
   logic         d4_busy, d4_ready, d4_dv;
   logic [159:0] d4_digest;

   logic [7:0]   msgb [128];
   int           checks, errors;

   sha_stream_core #(.LEN_W(32), .IN_BYTES(1)) dut1 (
      .clk(clk), .rst(rst), .start(s1_start), .msg_len(s1_len), .mode_sha1(s1_mode),
      .busy(d1_busy), .in_valid(s1_valid), .in_data(s1_data), .in_ready(d1_ready),
      .digest(d1_digest), .digest_valid(d1_dv)
   );

   sha_stream_core #(.LEN_W(32), .IN_BYTES(4)) dut4 (
      .clk(clk), .rst(rst), .start(s4_start), .msg_len(s4_len), .mode_sha1(s4_mode),
      .busy(d4_busy), .in_valid(s4_valid), .in_data(s4_data), .in_ready(d4_ready),
      .digest(d4_digest), .digest_valid(d4_dv)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic load_msg(input string s);
      for (int i = 0; i < 128; i++) msgb[i] = 8'hFF;
      for (int i = 0; i < s.len(); i++) msgb[i] = s[i];
   endtask

   // Runs one message on the selected core and reports what was observed.
   task automatic run_msg(input bit sel, input bit sha1, input int n, input bit gaps, input int stray,
                          output logic [159:0] dg, output int beats, output int ready_seen,
                          output bit busy_at_dv, output bit dv_next, output bit timed_out);
      int idx, cyc;
      bit got, xfer, rdy, vld;
      idx = 0; cyc = 0; got = 0; beats = 0; ready_seen = 0;
      busy_at_dv = 1'b1; dv_next = 1'b1; timed_out = 1'b0; dg = '0;
      @(negedge clk);
      if (sel) begin s4_start = 1'b1; s4_len = 32'(n); s4_mode = sha1; end
      else     begin s1_start = 1'b1; s1_len = 32'(n); s1_mode = sha1; end
      @(negedge clk);
      s1_start = 1'b0; s4_start = 1'b0;
      while (!got && cyc < 3000) begin
         if (cyc == stray) begin
            if (sel) begin s4_start = 1'b1; s4_len = '0; s4_mode = ~sha1; end
            else     begin s1_start = 1'b1; s1_len = '0; s1_mode = ~sha1; end
         end else begin
            s1_start = 1'b0; s4_start = 1'b0;
         end
         rdy = sel ? d4_ready : d1_ready;
         if (sel ? d4_dv : d1_dv) begin
            got = 1'b1;
            dg = sel ? d4_digest : d1_digest;
            busy_at_dv = sel ? d4_busy : d1_busy;
         end else begin
            if (rdy) ready_seen++;
            vld = (idx < n) && (!gaps || $urandom_range(0, 2) != 0);
            if (sel) begin
               s4_valid = vld;
               s4_data = {msgb[idx], msgb[idx+1], msgb[idx+2], msgb[idx+3]};
            end else begin
               s1_valid = vld;
               s1_data = msgb[idx];
            end
            xfer = vld && rdy;
            @(negedge clk);
            if (xfer) begin beats++; idx += sel ? 4 : 1; end
            cyc++;
         end
      end
      s1_valid = 1'b0; s4_valid = 1'b0; s1_start = 1'b0; s4_start = 1'b0;
      if (!got) timed_out = 1'b1;
      else begin
         @(negedge clk);
         dv_next = sel ? d4_dv : d1_dv;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (d1_busy !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %b want 0", d1_busy); end
      checks++; if (d1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1: got %b want 0", d1_ready); end
      checks++; if (d1_dv !== 1'b0) begin errors++; $display("FAIL reset_dv1: got %b want 0", d1_dv); end
      checks++; if (d1_digest !== 160'h0) begin errors++; $display("FAIL reset_digest1: got %h want 0", d1_digest); end
      checks++; if (d4_digest !== 160'h0) begin errors++; $display("FAIL reset_digest4: got %h want 0", d4_digest); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (d4_ready !== 1'b0 || d4_busy !== 1'b0) begin
         errors++; $display("FAIL idle_after_reset4: ready=%b busy=%b want 0 0", d4_ready, d4_busy);
      end
   endtask

   task automatic test_sha1_abc;
      logic [159:0] dg; int bt, rs; bit bz, dn, to;
      load_msg("abc");
      run_msg(1'b0, 1'b1, 3, 1'b0, -1, dg, bt, rs, bz, dn, to);
      checks++; if (to) begin errors++; $display("FAIL sha1_abc_timeout: no digest_valid within budget"); end
      checks++; if (dg !== SHA1_ABC) begin errors++; $display("FAIL sha1_abc_digest: got %h want %h", dg, SHA1_ABC); end
      checks++; if (bz !== 1'b0) begin errors++; $display("FAIL sha1_abc_busy_at_dv: got %b want 0", bz); end
      checks++; if (dn !== 1'b0) begin errors++; $display("FAIL sha1_abc_dv_width: dv next cycle %b want 0", dn); end
      checks++; if (bt != 3) begin errors++; $display("FAIL sha1_abc_beats: got %0d want 3", bt); end
   endtask

   task automatic test_sha0_abc;
      logic [159:0] dg; int bt, rs; bit bz, dn, to;
      load_msg("abc");
      run_msg(1'b0, 1'b0, 3, 1'b1, -1, dg, bt, rs, bz, dn, to);
      checks++; if (to) begin errors++; $display("FAIL sha0_abc_timeout: no digest_valid within budget"); end
      checks++; if (dg !== SHA0_ABC) begin errors++; $display("FAIL sha0_abc_digest: got %h want %h", dg, SHA0_ABC); end
   endtask

   task automatic test_empty;
      logic [159:0] dg; int bt, rs; bit bz, dn, to;
      load_msg("");
      run_msg(1'b0, 1'b1, 0, 1'b0, -1, dg, bt, rs, bz, dn, to);
      checks++; if (to) begin errors++; $display("FAIL empty_timeout: no digest_valid within budget"); end
      checks++; if (dg !== SHA1_EMPTY) begin errors++; $display("FAIL empty_digest: got %h want %h", dg, SHA1_EMPTY); end
      checks++; if (rs != 0) begin errors++; $display("FAIL empty_in_ready: ready seen %0d cycles want 0", rs); end
   endtask

   task automatic test_two_pad_blocks;
      logic [159:0] dg; int bt, rs; bit bz, dn, to;
      load_msg("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
      run_msg(1'b1, 1'b1, 56, 1'b1, -1, dg, bt, rs, bz, dn, to);
      checks++; if (to) begin errors++; $display("FAIL two_pad_timeout: no digest_valid within budget"); end
      checks++; if (dg !== SHA1_56B) begin errors++; $display("FAIL two_pad_digest: got %h want %h", dg, SHA1_56B); end
      checks++; if (bt != 14) begin errors++; $display("FAIL two_pad_beats: got %0d want 14", bt); end
      checks++; if (dn !== 1'b0) begin errors++; $display("FAIL two_pad_dv_width: dv next cycle %b want 0", dn); end
   endtask

   task automatic test_wide_beat_stray_start;
      logic [159:0] dg; int bt, rs; bit bz, dn, to, extra;
      load_msg("abc");
      run_msg(1'b1, 1'b1, 3, 1'b0, 100, dg, bt, rs, bz, dn, to);
      checks++; if (to) begin errors++; $display("FAIL wide_abc_timeout: no digest_valid within budget"); end
      checks++; if (dg !== SHA1_ABC) begin errors++; $display("FAIL wide_abc_digest: got %h want %h", dg, SHA1_ABC); end
      checks++; if (bt != 1) begin errors++; $display("FAIL wide_abc_beats: got %0d want 1", bt); end
      extra = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (d4_dv || d4_busy) extra = 1'b1;
      end
      checks++; if (extra) begin errors++; $display("FAIL stray_start_activity: core restarted, want idle"); end
      checks++; if (d4_digest !== SHA1_ABC) begin errors++; $display("FAIL stray_start_digest: got %h want %h", d4_digest, SHA1_ABC); end
   endtask

   task automatic test_abort_reset;
      logic [159:0] dg; int bt, rs, cyc; bit bz, dn, to, extra;
      for (int i = 0; i < 128; i++) msgb[i] = 8'h61;
      @(negedge clk);
      s1_start = 1'b1; s1_len = 32'd64; s1_mode = 1'b1;
      @(negedge clk);
      s1_start = 1'b0;
      bt = 0; cyc = 0;
      while (bt < 64 && cyc < 500) begin
         s1_valid = 1'b1; s1_data = msgb[bt];
         bz = d1_ready;
         @(negedge clk);
         if (bz) bt++;
         cyc++;
      end
      s1_valid = 1'b0;
      checks++; if (bt != 64) begin errors++; $display("FAIL abort_feed: accepted %0d want 64", bt); end
      repeat (30) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++; if (d1_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", d1_busy); end
      checks++; if (d1_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b want 0", d1_ready); end
      checks++; if (d1_digest !== 160'h0) begin errors++; $display("FAIL abort_digest: got %h want 0", d1_digest); end
      @(negedge clk);
      rst = 1'b0;
      extra = 1'b0;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (d1_dv || d1_busy) extra = 1'b1;
      end
      checks++; if (extra) begin errors++; $display("FAIL abort_resumed: activity after reset, want idle"); end
      load_msg("abc");
      run_msg(1'b0, 1'b1, 3, 1'b0, -1, dg, bt, rs, bz, dn, to);
      checks++; if (to) begin errors++; $display("FAIL post_abort_timeout: no digest_valid within budget"); end
      checks++; if (dg !== SHA1_ABC) begin errors++; $display("FAIL post_abort_digest: got %h want %h", dg, SHA1_ABC); end
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b1;
      s1_start = 1'b0; s1_mode = 1'b0; s1_valid = 1'b0; s1_len = '0; s1_data = '0;
      s4_start = 1'b0; s4_mode = 1'b0; s4_valid = 1'b0; s4_len = '0; s4_data = '0;
      test_reset();
      test_sha1_abc();
      test_sha0_abc();
      test_empty();
      test_two_pad_blocks();
      test_wide_beat_stray_start();
      test_abort_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
